// File: rtl/usb_host_pkg.sv
// rtl/usb_host_pkg.sv - shared encodings for the USB host port controller
// Contents: connectState encodings from the receiver, port FSM state encodings,
// and a helper that recognises a valid (low- or full-speed) attach.
package usb_host_pkg;

    typedef enum logic [1:0] {
        DISCONNECT    = 2'd0,
        LOW_SPEED     = 2'd1,
        FULL_SPEED    = 2'd2,
        CONN_RESERVED = 2'd3
    } connState_t;

    typedef enum logic [2:0] {
        ST_DISCONNECTED = 3'd0,
        ST_DEBOUNCE     = 3'd1,
        ST_BUS_RESET    = 3'd2,
        ST_RECOVERY     = 3'd3,
        ST_ENABLED      = 3'd4
    } portState_t;

    // The reserved code is treated exactly like a disconnect.
    function automatic logic isAttached(input logic [1:0] cs);
        return (cs == LOW_SPEED) || (cs == FULL_SPEED);
    endfunction

endpackage

// File: rtl/usb_host_port_ctrl_if.sv
// rtl/usb_host_port_ctrl_if.sv - status/control bundle between receiver, port FSM and packet engine
// master: the port controller (samples connectState/busResetReq, drives status).
// slave:  the surrounding system (drives connectState/busResetReq, reads status).
interface usb_host_port_ctrl_if;
    logic [1:0] connectState;
    logic       busResetReq;
    logic       txForceSE0;
    logic       txGrant;
    logic       portEnable;
    logic       portFullSpeed;
    logic       connectEvent;
    logic       disconnectEvent;
    logic [2:0] portState;

    modport master (
        input  connectState, busResetReq,
        output txForceSE0, txGrant, portEnable, portFullSpeed,
               connectEvent, disconnectEvent, portState
    );

    modport slave (
        output connectState, busResetReq,
        input  txForceSE0, txGrant, portEnable, portFullSpeed,
               connectEvent, disconnectEvent, portState
    );
endinterface

// File: rtl/usb_port_timer.sv
// rtl/usb_port_timer.sv - 16-bit clear/increment cycle counter with terminal compare
// Ports: clk, rst (async, active-high); clear restarts the count at 0 on the next
// edge; done is high while the registered count equals limit.
module usb_port_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] limit,
    output logic        done
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/usb_host_port_ctrl.sv
// rtl/usb_host_port_ctrl.sv - USB host root-port state machine (attach debounce, bus reset, recovery)
// Ports: clk, rst (async, active-high); bus (master modport): connectState and
// busResetReq in; txForceSE0, txGrant, portEnable, portFullSpeed, connectEvent,
// disconnectEvent, portState out. All cycle parameters must be at least 1.
module usb_host_port_ctrl
    import usb_host_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter logic [15:0] RESET_CYCLES    = 16'd480,
    parameter logic [15:0] RECOVERY_CYCLES = 16'd200
) (
    input  logic                 clk,
    input  logic                 rst,
    usb_host_port_ctrl_if.master bus
);

    portState_t  state, stateNext;
    logic        fullSpeed;
    logic        latchSpeed;
    logic        discEvent, discEventNext;
    logic [15:0] limit;
    logic        timerDone;
    logic        attached;
    logic        speedMatch;

    assign attached   = isAttached(bus.connectState);
    assign speedMatch = (bus.connectState == (fullSpeed ? FULL_SPEED : LOW_SPEED));

    // The counter restarts on every state change, so each state times itself.
    usb_port_timer uTimer (
        .clk   (clk),
        .rst   (rst),
        .clear (stateNext != state),
        .limit (limit),
        .done  (timerDone)
    );

    always_comb begin
        stateNext     = state;
        discEventNext = 1'b0;
        latchSpeed    = 1'b0;
        limit         = 16'd0;
        case (state)
            ST_DISCONNECTED: begin
                if (attached) begin
                    stateNext  = ST_DEBOUNCE;
                    latchSpeed = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                limit = DEBOUNCE_CYCLES - 16'd1;
                // The terminal cycle always completes: connectEvent is decoded from
                // registered state only, so it must not be retracted by an input.
                if (timerDone) begin
                    stateNext = ST_BUS_RESET;
                end else if (!speedMatch) begin
                    stateNext = ST_DISCONNECTED;
                end
            end
            ST_BUS_RESET: begin
                limit = RESET_CYCLES - 16'd1;
                if (timerDone) begin
                    stateNext = ST_RECOVERY;
                end
            end
            ST_RECOVERY: begin
                limit = RECOVERY_CYCLES - 16'd1;
                if (timerDone) begin
                    if (speedMatch) begin
                        stateNext = ST_ENABLED;
                    end else begin
                        stateNext     = ST_DISCONNECTED;
                        discEventNext = 1'b1;
                    end
                end
            end
            ST_ENABLED: begin
                // Loss of the device outranks a pending reset request.
                if (!attached) begin
                    stateNext     = ST_DISCONNECTED;
                    discEventNext = 1'b1;
                end else if (bus.busResetReq) begin
                    stateNext = ST_BUS_RESET;
                end
            end
            default: begin
                stateNext = ST_DISCONNECTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_DISCONNECTED;
            fullSpeed <= 1'b0;
            discEvent <= 1'b0;
        end else begin
            state     <= stateNext;
            discEvent <= discEventNext;
            if (latchSpeed) begin
                fullSpeed <= (bus.connectState == FULL_SPEED);
            end
        end
    end

    // Pure decodes of registered state, so reset clears them without a clock edge.
    assign bus.txForceSE0      = (state == ST_BUS_RESET);
    assign bus.txGrant         = (state == ST_ENABLED);
    assign bus.portEnable      = (state == ST_ENABLED);
    assign bus.portFullSpeed   = fullSpeed;
    assign bus.connectEvent    = (state == ST_DEBOUNCE) && timerDone;
    assign bus.disconnectEvent = discEvent;
    assign bus.portState       = state;

endmodule

// File: doc/usb_host_port_ctrl.md
USB_HOST_PORT_CTRL -- requirements
Module: usb_host_port_ctrl

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 16'd1000: cycles a non-zero connect state must be held before the port accepts it.
- REQ-002: Parameter RESET_CYCLES, default 16'd480: cycles the bus is forced to SE0 during a bus reset.
- REQ-003: Parameter RECOVERY_CYCLES, default 16'd200: post-reset cycles before the connect state is re-checked; SHALL exceed the receiver's 121-sample reconnect window.
- REQ-004: Each parameter SHALL be at least 1.
- REQ-005: Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-006: Port rst, input, 1 bit: reset, asynchronous and active-high.
- REQ-007: Port connectState, input, 2 bits: receiver status; 0 = disconnected, 1 = low speed, 2 = full speed, 3 = reserved and treated as 0.
- REQ-008: Port busResetReq, input, 1 bit: level request for a bus reset, sampled only in ENABLED.
- REQ-009: Port txForceSE0, output, 1 bit: drives SE0 on the wire transmitter.
- REQ-010: Port txGrant, output, 1 bit: packet engine may use the transmitter.
- REQ-011: Port portEnable, output, 1 bit: port is enabled.
- REQ-012: Port portFullSpeed, output, 1 bit: latched speed; 1 = full speed, 0 = low speed.
- REQ-013: Port connectEvent, output, 1 bit: one-cycle pulse when debounce completes.
- REQ-014: Port disconnectEvent, output, 1 bit: one-cycle pulse when a connected port is lost.
- REQ-015: Port portState, output, 3 bits: current FSM state encoding.

Function
- REQ-016: FSM states and encodings SHALL be DISCONNECTED=0, DEBOUNCE=1, BUS_RESET=2, RECOVERY=3, ENABLED=4.
- REQ-017: A single 16-bit cycle counter SHALL be cleared on every state entry and increment each cycle otherwise.
- REQ-018: DISCONNECTED -> DEBOUNCE when connectState is 1 or 2; latch portFullSpeed = (connectState==2) in the same cycle.
- REQ-019: DEBOUNCE -> DISCONNECTED, with no event, if connectState differs from the latched speed.
- REQ-020: DEBOUNCE -> BUS_RESET when the counter reaches DEBOUNCE_CYCLES-1, with connectEvent=1 for that cycle.
- REQ-021: BUS_RESET: txForceSE0=1 and connectState ignored; -> RECOVERY when the counter reaches RESET_CYCLES-1.
- REQ-022: RECOVERY: connectState ignored until the counter reaches RECOVERY_CYCLES-1.
- REQ-023: At the end of RECOVERY -> ENABLED if connectState matches the latched speed; otherwise -> DISCONNECTED with disconnectEvent=1.
- REQ-024: ENABLED: portEnable=1 and txGrant=1.
- REQ-025: In ENABLED, connectState==0 (or 3) -> DISCONNECTED with disconnectEvent=1; this has priority over busResetReq in the same cycle.
- REQ-026: ENABLED with busResetReq=1 -> BUS_RESET; portEnable and txGrant drop in the next cycle.
- REQ-027: txGrant and txForceSE0 SHALL never both be 1.
- REQ-028: busResetReq outside ENABLED SHALL be ignored, not queued.
- REQ-029: portFullSpeed SHALL hold its latched value until the next DISCONNECTED -> DEBOUNCE transition.
- REQ-030: All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
- REQ-031: On rst, asynchronously: state=DISCONNECTED, counter=0, all outputs 0 (portState=0).
- REQ-032: rst asserted mid BUS_RESET SHALL release txForceSE0 immediately, without waiting for a clock.
- REQ-033: The first state transition after rst deassertion SHALL occur no earlier than the first rising clk edge.

Structure
- REQ-034: Shared package usb_host_pkg SHALL hold the connectState encodings (DISCONNECT/LOW_SPEED/FULL_SPEED) and the port FSM state encodings.
- REQ-035: One sub-module is natural: usb_port_timer, a 16-bit clear/increment counter with a terminal-compare output; everything else inline.

Verification (DEBOUNCE=4, RESET=8, RECOVERY=6)
- REQ-036: connectState=2 held -> DEBOUNCE at cycle 1; connectEvent at cycle 4; txForceSE0 high 8 cycles; ENABLED with portFullSpeed=1 at cycle 19.
- REQ-037: connectState=1 for 2 cycles, then 0 -> return to DISCONNECTED; no connectEvent or disconnectEvent pulse.
- REQ-038: ENABLED, connectState->0 and busResetReq=1 in the same cycle -> DISCONNECTED and one disconnectEvent; txForceSE0 stays 0.
- REQ-039: ENABLED, busResetReq=1 -> portEnable=0 next cycle, txForceSE0=1 for 8 cycles, then RECOVERY.
- REQ-040: connectState=0 at the end of RECOVERY -> DISCONNECTED with disconnectEvent pulse.
- REQ-041: rst asserted mid BUS_RESET -> txForceSE0=0 and portState=0 before the next clk edge.
